// File: rtl/spi_burst_slave_pkg.sv
// Shared encodings for the SPI-RAM slave front end and the RAM controller.
// Latency: n/a (types, encodings and a pure helper function only).
// Backpressure: n/a.
package spi_burst_slave_pkg;

   // Two-bit command sent MSB first at the start of every frame.
   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

   // Frame sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_WR_SHIFT = 3'd2,
      ST_RA_SHIFT = 3'd3,
      ST_RD_REQ   = 3'd4,
      ST_RD_WAIT  = 3'd5,
      ST_RD_SHIFT = 3'd6,
      ST_DRAIN    = 3'd7
   } state_t;

   // State entered once both command bits have been sampled.
   function automatic state_t cmd_dest(input cmd_t c);
      case (c)
         CMD_WR_ADDR, CMD_WR_DATA: cmd_dest = ST_WR_SHIFT;
         CMD_RD_ADDR:              cmd_dest = ST_RA_SHIFT;
         default:                  cmd_dest = ST_RD_REQ;
      endcase
   endfunction

endpackage

// File: rtl/spi_burst_slave_shift_reg.sv
// Serial-in/parallel-out and parallel-load/serial-out shift register, MSB first.
// Latency: load/shift take effect on the next clk edge; q is the register itself.
// Backpressure: none; the owner decides every cycle whether to clear, load or shift.
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] ld_data,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   // Clear beats load beats shift; shifting moves bits towards the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= ld_data;
      end else if (shift) begin
         q <= {q[W-2:0], sin};
      end
   end

endmodule

// File: rtl/spi_burst_slave.sv
// SPI slave front end: MOSI -> {cmd, word} tokens for the RAM controller, RAM read words -> MISO.
// Latency: rx_valid one clk after the last bit edge; first MISO bit one clk after tx_valid is taken.
// Backpressure: none on rx (strobe only); tx waits up to WAIT_MAX clks for tx_valid, then flags err.
module spi_burst_slave
   import spi_burst_slave_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int BURST_EN = 1,
   parameter int WAIT_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              busy,
   output logic              err
);

   localparam int BCNT_W = $clog2(DATA_W + 1);
   localparam int WCNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_W - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

   state_t              state, state_nxt;
   cmd_t                tag, tag_nxt;
   logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
   logic                err_nxt;
   logic                miso_nxt;
   logic                rx_valid_nxt;
   logic [DATA_W+1:0]   rx_data_nxt;
   logic                sr_clr, sr_load, sr_shift;
   logic [DATA_W-1:0]   sr_q;

   // One shift register serves both directions: receive shifts mosi in,
   // transmit is preloaded one bit ahead because the MSB goes straight to miso.
   spi_shift_reg #(.W(DATA_W)) u_sr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (sr_clr),
      .load    (sr_load),
      .ld_data ({tx_data[DATA_W-2:0], 1'b0}),
      .shift   (sr_shift),
      .sin     (mosi),
      .q       (sr_q)
   );

   assign busy = (state != ST_IDLE);

   // Next-state, counter and registered-output decode; ss_n high overrides everything.
   always_comb begin
      state_nxt    = state;
      tag_nxt      = tag;
      bcnt_nxt     = bcnt;
      wcnt_nxt     = wcnt;
      err_nxt      = err;
      miso_nxt     = 1'b0;
      rx_valid_nxt = 1'b0;
      rx_data_nxt  = rx_data;
      sr_clr       = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;

      if (ss_n) begin
         // Frame aborted or idle: any partial word is thrown away.
         state_nxt = ST_IDLE;
         bcnt_nxt  = '0;
         wcnt_nxt  = '0;
         sr_clr    = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               tag_nxt   = cmd_t'({mosi, 1'b0});
               err_nxt   = 1'b0;
               bcnt_nxt  = '0;
               state_nxt = ST_CMD;
            end

            ST_CMD: begin
               tag_nxt   = cmd_t'({tag[1], mosi});
               bcnt_nxt  = '0;
               state_nxt = cmd_dest(cmd_t'({tag[1], mosi}));
               if (cmd_t'({tag[1], mosi}) == CMD_RD_DATA) begin
                  rx_valid_nxt = 1'b1;
                  rx_data_nxt  = {CMD_RD_DATA, {DATA_W{1'b0}}};
               end
            end

            ST_WR_SHIFT: begin
               sr_shift = 1'b1;
               if (bcnt == BIT_LAST) begin
                  bcnt_nxt     = '0;
                  rx_valid_nxt = 1'b1;
                  rx_data_nxt  = {tag, sr_q[DATA_W-2:0], mosi};
                  // Follow-on burst words auto-increment on the RAM side.
                  if (BURST_EN != 0) begin
                     tag_nxt = CMD_WR_DATA;
                  end else begin
                     state_nxt = ST_DRAIN;
                  end
               end else begin
                  bcnt_nxt = bcnt + 1'b1;
               end
            end

            ST_RA_SHIFT: begin
               sr_shift = 1'b1;
               if (bcnt == BIT_LAST) begin
                  bcnt_nxt     = '0;
                  rx_valid_nxt = 1'b1;
                  rx_data_nxt  = {tag, sr_q[DATA_W-2:0], mosi};
                  state_nxt    = ST_DRAIN;
               end else begin
                  bcnt_nxt = bcnt + 1'b1;
               end
            end

            ST_RD_REQ: begin
               wcnt_nxt  = '0;
               state_nxt = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
               // tx_valid is checked before the timeout so a word arriving on
               // the last allowed edge is still served.
               if (tx_valid) begin
                  sr_load   = 1'b1;
                  miso_nxt  = tx_data[DATA_W-1];
                  bcnt_nxt  = '0;
                  state_nxt = ST_RD_SHIFT;
               end else if (wcnt == WAIT_LAST) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_DRAIN;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end

            ST_RD_SHIFT: begin
               sr_shift = 1'b1;
               if (bcnt == BIT_LAST) begin
                  bcnt_nxt = '0;
                  if (BURST_EN != 0) begin
                     rx_valid_nxt = 1'b1;
                     rx_data_nxt  = {CMD_RD_DATA, {DATA_W{1'b0}}};
                     state_nxt    = ST_RD_REQ;
                  end else begin
                     state_nxt = ST_DRAIN;
                  end
               end else begin
                  miso_nxt = sr_q[DATA_W-1];
                  bcnt_nxt = bcnt + 1'b1;
               end
            end

            ST_DRAIN: begin
               state_nxt = ST_DRAIN;
            end

            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tag      <= CMD_WR_ADDR;
         bcnt     <= '0;
         wcnt     <= '0;
         err      <= 1'b0;
         miso     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         state    <= state_nxt;
         tag      <= tag_nxt;
         bcnt     <= bcnt_nxt;
         wcnt     <= wcnt_nxt;
         err      <= err_nxt;
         miso     <= miso_nxt;
         rx_valid <= rx_valid_nxt;
         rx_data  <= rx_data_nxt;
      end
   end

endmodule

// File: tb/tb_spi_burst_slave.sv
// Directed bench for spi_burst_slave (DATA_W=8, BURST_EN=1, WAIT_MAX=4).
// Latency: inputs driven 1 time unit after each posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_spi_burst_slave;

   localparam int DATA_W   = 8;
   localparam int BURST_EN = 1;
   localparam int WAIT_MAX = 4;

   logic              clk;
   logic              rst_n;
   logic              ss_n;
   logic              mosi;
   logic              miso;
   logic [DATA_W+1:0] rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              busy;
   logic              err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int dbl    = 0;
   logic prev_vld = 1'b0;
   logic [DATA_W+1:0] sq[$];
   int                sc[$];

   typedef struct {
      logic [1:0]        cmd;
      logic [DATA_W-1:0] word;
      logic [DATA_W+1:0] exp_dat;
   } vec_t;

   vec_t vecs[6];

   spi_burst_slave #(
      .DATA_W   (DATA_W),
      .BURST_EN (BURST_EN),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and record any rx strobe with its cycle number.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rx_valid === 1'b1) begin
         if (prev_vld) dbl++;
         sq.push_back(rx_data);
         sc.push_back(cyc);
      end
      prev_vld = (rx_valid === 1'b1);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         tick();
      end
   endtask

   task automatic end_frame();
      ss_n = 1'b1;
      mosi = 1'b0;
      tick();
   endtask

   initial begin
      int c0;
      logic [7:0] mbyte;

      vecs[0] = '{2'b00, 8'hA5, 10'h0A5};
      vecs[1] = '{2'b01, 8'h5A, 10'h15A};
      vecs[2] = '{2'b10, 8'h3C, 10'h23C};
      vecs[3] = '{2'b00, 8'hFF, 10'h0FF};
      vecs[4] = '{2'b01, 8'h00, 10'h100};
      vecs[5] = '{2'b10, 8'h81, 10'h281};

      rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick(); tick(); tick();
      chk("reset miso",     32'(miso),     32'd0);
      chk("reset rx_valid", 32'(rx_valid), 32'd0);
      chk("reset rx_data",  32'(rx_data),  32'd0);
      chk("reset busy",     32'(busy),     32'd0);
      chk("reset err",      32'(err),      32'd0);
      rst_n = 1'b1;
      tick();

      // Single-word frames with a 3-bit trailing partial word.
      for (int v = 0; v < 6; v++) begin
         sq.delete(); sc.delete();
         c0 = cyc;
         ss_n = 1'b0;
         send_bits(32'(vecs[v].cmd), 2);
         send_bits(32'(vecs[v].word), 8);
         send_bits(32'h5, 3);
         end_frame();
         chk($sformatf("vec%0d strobes", v), 32'(sq.size()), 32'd1);
         if (sq.size() > 0) begin
            chk($sformatf("vec%0d rx_data", v), 32'(sq[0]), 32'(vecs[v].exp_dat));
            chk($sformatf("vec%0d latency", v), 32'(sc[0] - c0), 32'd10);
         end
         chk($sformatf("vec%0d busy after ss_n", v), 32'(busy), 32'd0);
      end

      // Write burst: 00 + 0x10, 0x11, 0x12.
      sq.delete(); sc.delete();
      c0 = cyc;
      ss_n = 1'b0;
      send_bits(32'h0, 2);
      send_bits(32'h10, 8);
      send_bits(32'h11, 8);
      send_bits(32'h12, 8);
      end_frame();
      chk("burst strobes", 32'(sq.size()), 32'd3);
      if (sq.size() == 3) begin
         chk("burst w0", 32'(sq[0]), 32'h010);
         chk("burst w1", 32'(sq[1]), 32'h111);
         chk("burst w2", 32'(sq[2]), 32'h112);
         chk("burst t0", 32'(sc[0] - c0), 32'd10);
         chk("burst gap1", 32'(sc[1] - sc[0]), 32'd8);
         chk("burst gap2", 32'(sc[2] - sc[1]), 32'd8);
      end

      // Read address with 16 extra bits then drain.
      sq.delete(); sc.delete();
      ss_n = 1'b0;
      send_bits(32'h2, 2);
      send_bits(32'h3C, 8);
      send_bits(32'hFFFF, 16);
      chk("ra busy in drain", 32'(busy), 32'd1);
      end_frame();
      chk("ra busy after ss_n", 32'(busy), 32'd0);
      chk("ra strobes", 32'(sq.size()), 32'd1);
      if (sq.size() > 0) chk("ra rx_data", 32'(sq[0]), 32'h23C);

      // Read data burst: word 0xC3, second request, then timeout.
      sq.delete(); sc.delete();
      ss_n = 1'b0;
      send_bits(32'h3, 2);
      chk("rd req rx_valid", 32'(rx_valid), 32'd1);
      chk("rd req rx_data",  32'(rx_data),  32'h300);
      mosi = 1'b1;
      tick();
      chk("rd wait miso", 32'(miso), 32'd0);
      tx_valid = 1'b1; tx_data = 8'hC3;
      tick();
      tx_valid = 1'b0; tx_data = 8'h00;
      mbyte = 8'h00;
      mbyte = {mbyte[6:0], miso};
      for (int i = 0; i < 7; i++) begin
         tick();
         mbyte = {mbyte[6:0], miso};
      end
      chk("rd miso byte", 32'(mbyte), 32'hC3);
      chk("rd no early strobe", 32'(sq.size()), 32'd1);
      tick();
      chk("rd burst strobe", 32'(rx_valid), 32'd1);
      chk("rd burst rx_data", 32'(rx_data), 32'h300);
      chk("rd burst miso idle", 32'(miso), 32'd0);
      tick();
      tick(); tick(); tick();
      chk("timeout err before", 32'(err), 32'd0);
      tick();
      chk("timeout err set", 32'(err), 32'd1);
      chk("timeout miso", 32'(miso), 32'd0);
      chk("timeout busy", 32'(busy), 32'd1);
      tick();
      chk("drain rx_data held", 32'(rx_data), 32'h300);
      end_frame();
      chk("err sticky after ss_n", 32'(err), 32'd1);
      ss_n = 1'b0; mosi = 1'b0;
      tick();
      chk("err cleared at frame start", 32'(err), 32'd0);
      end_frame();

      // tx_valid on the final RD_WAIT edge is accepted.
      ss_n = 1'b0;
      send_bits(32'h3, 2);
      tick();
      tick(); tick(); tick();
      tx_valid = 1'b1; tx_data = 8'h81;
      tick();
      tx_valid = 1'b0; tx_data = 8'h00;
      chk("late tx err", 32'(err), 32'd0);
      chk("late tx miso msb", 32'(miso), 32'd1);
      tick();
      chk("late tx miso b6", 32'(miso), 32'd0);
      end_frame();

      // Abort after 5 data bits; tx_valid outside RD_WAIT must do nothing.
      sq.delete(); sc.delete();
      ss_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF;
      send_bits(32'h0, 2);
      send_bits(32'h1F, 5);
      chk("abort5 miso", 32'(miso), 32'd0);
      end_frame();
      tx_valid = 1'b0; tx_data = 8'h00;
      tick();
      chk("abort5 strobes", 32'(sq.size()), 32'd0);
      chk("abort5 busy", 32'(busy), 32'd0);

      // ss_n rises on the edge of the last data bit.
      sq.delete(); sc.delete();
      ss_n = 1'b0;
      send_bits(32'h1, 2);
      send_bits(32'h55, 7);
      mosi = 1'b1; ss_n = 1'b1;
      tick();
      tick();
      chk("abort8 strobes", 32'(sq.size()), 32'd0);

      // Reset in the middle of RD_SHIFT.
      sq.delete(); sc.delete();
      ss_n = 1'b0;
      send_bits(32'h3, 2);
      tick();
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0; tx_data = 8'h00;
      tick();
      chk("pre-reset miso", 32'(miso), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("midrst miso",     32'(miso),     32'd0);
      chk("midrst rx_valid", 32'(rx_valid), 32'd0);
      chk("midrst rx_data",  32'(rx_data),  32'd0);
      chk("midrst busy",     32'(busy),     32'd0);
      chk("midrst err",      32'(err),      32'd0);
      chk("midrst strobes",  32'(sq.size()), 32'd1);
      ss_n = 1'b1; rst_n = 1'b1;
      tick();

      chk("no back-to-back strobes", 32'(dbl), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
